// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator.
package video_timing_pkg;

  localparam int unsigned CW_DEFAULT   = 12;
  localparam int unsigned DE_DELAY_MIN = 1;
  localparam int unsigned DE_DELAY_MAX = 8;

  typedef struct packed {
    logic [CW_DEFAULT-1:0] h_total;
    logic [CW_DEFAULT-1:0] h_sync;
    logic [CW_DEFAULT-1:0] h_start;
    logic [CW_DEFAULT-1:0] h_end;
    logic [CW_DEFAULT-1:0] v_total;
    logic [CW_DEFAULT-1:0] v_sync;
    logic [CW_DEFAULT-1:0] v_start;
    logic [CW_DEFAULT-1:0] v_end;
    logic                  hs_pol;
    logic                  vs_pol;
  } timing_cfg_t;

  // bit0 = cfg_ready, bit1 = running, so both pins come straight off the state flops
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_RUN  = 2'b11,
    ST_PEND = 2'b10
  } cfg_state_t;

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active/offset decode.
module timing_axis_counter #(
  parameter int unsigned CW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] total,
  input  logic [CW-1:0] sync,
  input  logic [CW-1:0] start,
  input  logic [CW-1:0] stop,
  input  logic          step,
  input  logic          load,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync_act,
  output logic          act,
  output logic [CW-1:0] offset
);

  // >= rather than == so a total below the current count still wraps
  assign wrap     = (count >= total);
  assign sync_act = (count < sync);
  assign act      = (count >= start) && (count < stop);
  assign offset   = count - start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator with frame-boundary config updates.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned CW       = 12,
  parameter int unsigned DE_DELAY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_h_total,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_start,
  input  logic [CW-1:0] cfg_h_end,
  input  logic [CW-1:0] cfg_v_total,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_start,
  input  logic [CW-1:0] cfg_v_end,
  input  logic          cfg_hs_pol,
  input  logic          cfg_vs_pol,
  output logic          running,
  output logic          hdmi_hs,
  output logic          hdmi_vs,
  output logic          hdmi_de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          sof,
  output logic          eol
);

  if (DE_DELAY < DE_DELAY_MIN || DE_DELAY > DE_DELAY_MAX) begin : g_bad_delay
    $error("video_timing_gen: DE_DELAY out of range");
  end

  // Same layout as timing_cfg_t, sized by this instance's CW
  typedef struct packed {
    logic [CW-1:0] h_total;
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_start;
    logic [CW-1:0] h_end;
    logic [CW-1:0] v_total;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_start;
    logic [CW-1:0] v_end;
    logic          hs_pol;
    logic          vs_pol;
  } cfg_t;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          sof;
    logic          eol;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pix_out_t;

  localparam pix_out_t OUT_IDLE = '{hs: 1'b1, vs: 1'b1, default: '0};

  cfg_state_t    state, state_nxt;
  cfg_t          cfg_in, active, shadow;
  logic          boundary;
  logic          h_wrap, v_wrap, h_sync_act, v_sync_act, h_act, v_act;
  logic [CW-1:0] h_count, v_count, h_off, v_off;
  pix_out_t      raw;
  pix_out_t      pipe [DE_DELAY];

  assign cfg_in = '{h_total: cfg_h_total, h_sync: cfg_h_sync,
                    h_start: cfg_h_start, h_end: cfg_h_end,
                    v_total: cfg_v_total, v_sync: cfg_v_sync,
                    v_start: cfg_v_start, v_end: cfg_v_end,
                    hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};

  assign cfg_ready = state[0];
  assign running   = state[1];
  assign boundary  = running && h_wrap && v_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (cfg_valid) state_nxt = ST_RUN;
      ST_RUN:  if (cfg_valid) state_nxt = ST_PEND;
      ST_PEND: if (boundary)  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A set accepted while running always waits in the shadow for the next boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= '0;
      shadow <= '0;
    end else begin
      if (state == ST_IDLE && cfg_valid)     active <= cfg_in;
      else if (state == ST_PEND && boundary) active <= shadow;
      if (state == ST_RUN && cfg_valid)      shadow <= cfg_in;
    end
  end

  timing_axis_counter #(.CW(CW)) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .total    (active.h_total),
    .sync     (active.h_sync),
    .start    (active.h_start),
    .stop     (active.h_end),
    .step     (running),
    .load     (state == ST_IDLE && cfg_valid),
    .count    (h_count),
    .wrap     (h_wrap),
    .sync_act (h_sync_act),
    .act      (h_act),
    .offset   (h_off)
  );

  timing_axis_counter #(.CW(CW)) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .total    (active.v_total),
    .sync     (active.v_sync),
    .start    (active.v_start),
    .stop     (active.v_end),
    .step     (running && h_wrap),
    .load     (state == ST_IDLE && cfg_valid),
    .count    (v_count),
    .wrap     (v_wrap),
    .sync_act (v_sync_act),
    .act      (v_act),
    .offset   (v_off)
  );

  always_comb begin
    raw = OUT_IDLE;
    if (running) begin
      raw.hs = h_sync_act ? active.hs_pol : ~active.hs_pol;
      raw.vs = v_sync_act ? active.vs_pol : ~active.vs_pol;
      raw.de = h_act && v_act;
      if (h_act && v_act) begin
        raw.x   = h_off;
        raw.y   = v_off;
        raw.sof = (h_count == active.h_start) && (v_count == active.v_start);
        raw.eol = (h_count == active.h_end - CW'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DE_DELAY; i++) pipe[i] <= OUT_IDLE;
    end else begin
      pipe[0] <= raw;
      for (int unsigned i = 1; i < DE_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign hdmi_hs = pipe[DE_DELAY-1].hs;
  assign hdmi_vs = pipe[DE_DELAY-1].vs;
  assign hdmi_de = pipe[DE_DELAY-1].de;
  assign sof     = pipe[DE_DELAY-1].sof;
  assign eol     = pipe[DE_DELAY-1].eol;
  assign pix_x   = pipe[DE_DELAY-1].x;
  assign pix_y   = pipe[DE_DELAY-1].y;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: table-driven frame statistics, corner sequences, random configs vs an arithmetic model.
module tb_video_timing_gen;

  localparam int unsigned CW = 12;
  localparam int unsigned D  = 3;

  typedef struct packed {
    logic [CW-1:0] ht, hs, hst, he, vt, vs, vst, ve;
    logic          hp, vp;
  } tcfg_t;

  typedef struct packed {
    logic          hs, vs, de, sof, eol;
    logic [CW-1:0] x, y;
  } vout_t;

  typedef struct {
    tcfg_t       cfg;
    int unsigned win, de_n, hs_n, vs_n, sof_n, eol_n;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, cfg_valid, cfg_ready, running;
  logic          hdmi_hs, hdmi_vs, hdmi_de, sof, eol;
  logic [CW-1:0] pix_x, pix_y;
  tcfg_t         cin;

  int unsigned total = 0;
  int unsigned bad   = 0;

  bit          m_run, m_pend;
  tcfg_t       m_cur, m_sh;
  int unsigned m_k;
  vout_t       m_q[$];

  always #5 clk = ~clk;

  video_timing_gen #(.CW(CW), .DE_DELAY(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_h_total (cin.ht),
    .cfg_h_sync  (cin.hs),
    .cfg_h_start (cin.hst),
    .cfg_h_end   (cin.he),
    .cfg_v_total (cin.vt),
    .cfg_v_sync  (cin.vs),
    .cfg_v_start (cin.vst),
    .cfg_v_end   (cin.ve),
    .cfg_hs_pol  (cin.hp),
    .cfg_vs_pol  (cin.vp),
    .running     (running),
    .hdmi_hs     (hdmi_hs),
    .hdmi_vs     (hdmi_vs),
    .hdmi_de     (hdmi_de),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .sof         (sof),
    .eol         (eol)
  );

  function automatic tcfg_t mk(int unsigned ht, int unsigned hs, int unsigned hst, int unsigned he,
                               int unsigned vt, int unsigned vs, int unsigned vst, int unsigned ve,
                               bit hp, bit vp);
    tcfg_t c;
    c.ht = CW'(ht); c.hs = CW'(hs); c.hst = CW'(hst); c.he = CW'(he);
    c.vt = CW'(vt); c.vs = CW'(vs); c.vst = CW'(vst); c.ve = CW'(ve);
    c.hp = hp; c.vp = vp;
    return c;
  endfunction

  function automatic int unsigned period(tcfg_t c);
    return (32'(c.ht) + 1) * (32'(c.vt) + 1);
  endfunction

  function automatic vout_t idle_out();
    vout_t o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Expected pins for the k-th clock of a frame, from line/frame arithmetic
  function automatic vout_t raw_of(tcfg_t c, int unsigned k);
    int unsigned hn = 32'(c.ht) + 1;
    int unsigned h  = k % hn;
    int unsigned v  = (k / hn) % (32'(c.vt) + 1);
    vout_t o = '0;
    o.hs = (h < 32'(c.hs)) ? c.hp : !c.hp;
    o.vs = (v < 32'(c.vs)) ? c.vp : !c.vp;
    o.de = (h >= 32'(c.hst)) && (h < 32'(c.he)) && (v >= 32'(c.vst)) && (v < 32'(c.ve));
    if (o.de) begin
      o.x   = CW'(h - 32'(c.hst));
      o.y   = CW'(v - 32'(c.vst));
      o.sof = (h == 32'(c.hst)) && (v == 32'(c.vst));
      o.eol = (h + 1 == 32'(c.he));
    end
    return o;
  endfunction

  function automatic tcfg_t rand_cfg();
    int unsigned ht  = $urandom_range(20, 4);
    int unsigned hs  = $urandom_range(ht - 2, 0);
    int unsigned hst = $urandom_range(ht, hs + 1);
    int unsigned he  = $urandom_range(ht + 1, hst + 1);
    int unsigned vt  = $urandom_range(8, 2);
    int unsigned vs  = $urandom_range(vt - 2, 0);
    int unsigned vst = $urandom_range(vt, vs + 1);
    int unsigned ve  = $urandom_range(vt + 1, vst + 1);
    return mk(ht, hs, hst, he, vt, vs, vst, ve, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle(string name);
    vout_t e = m_q[0];
    chk(name,
        64'({cfg_ready, running, hdmi_hs, hdmi_vs, hdmi_de, sof, eol, pix_x, pix_y}),
        64'({!m_pend, m_run, e.hs, e.vs, e.de, e.sof, e.eol, e.x, e.y}));
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pend = 1'b0; m_k = 0;
    m_q.delete();
    repeat (D) m_q.push_back(idle_out());
  endtask

  task automatic model_edge(logic v, tcfg_t c);
    bit acc = v && !m_pend;
    m_q.push_back(m_run ? raw_of(m_cur, m_k) : idle_out());
    void'(m_q.pop_front());
    if (!m_run) begin
      if (acc) begin m_run = 1'b1; m_cur = c; m_k = 0; end
    end else begin
      if (m_pend && m_k == period(m_cur) - 1) begin
        m_cur = m_sh; m_pend = 1'b0; m_k = 0;
      end else begin
        m_k = (m_k + 1) % period(m_cur);
      end
      if (acc) begin m_sh = c; m_pend = 1'b1; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(cfg_valid, cin);
    @(negedge clk);
    check_cycle("cycle");
  endtask

  task automatic hw_reset();
    @(negedge clk);
    reset = 1'b1;
    #1 model_reset();
    check_cycle("reset_state");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_cfg(tcfg_t c);
    cin = c; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[4];
    tcfg_t       s_ref, s_p, s_b;
    int unsigned n, first_hs, first_de, de_n, hs_n, vs_n, sof_n, eol_n, e0, e1, ne;

    tbl[0] = '{mk(9, 2, 3, 8, 5, 1, 2, 5, 0, 0),    60, 15, 12, 10, 1, 3};
    tbl[1] = '{mk(15, 3, 4, 12, 7, 2, 3, 6, 1, 1), 128, 24, 24, 32, 1, 3};
    tbl[2] = '{mk(9, 2, 12, 14, 5, 1, 2, 5, 0, 0),  60,  0, 12, 10, 0, 0};
    tbl[3] = '{mk(3, 0, 1, 4, 2, 0, 1, 3, 0, 1),    12,  6,  0,  0, 1, 2};

    reset = 1'b1; cfg_valid = 1'b0; cin = '0;
    model_reset();
    #2 check_cycle("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      hw_reset();
      load_cfg(tbl[i].cfg);
      repeat (D) step();
      de_n = 0; hs_n = 0; vs_n = 0; sof_n = 0; eol_n = 0;
      repeat (tbl[i].win) begin
        step();
        de_n  += 32'(hdmi_de);
        hs_n  += 32'(hdmi_hs == tbl[i].cfg.hp);
        vs_n  += 32'(hdmi_vs == tbl[i].cfg.vp);
        sof_n += 32'(sof);
        eol_n += 32'(eol);
      end
      chk($sformatf("tbl%0d_de", i),  64'(de_n),  64'(tbl[i].de_n));
      chk($sformatf("tbl%0d_hs", i),  64'(hs_n),  64'(tbl[i].hs_n));
      chk($sformatf("tbl%0d_vs", i),  64'(vs_n),  64'(tbl[i].vs_n));
      chk($sformatf("tbl%0d_sof", i), 64'(sof_n), 64'(tbl[i].sof_n));
      chk($sformatf("tbl%0d_eol", i), 64'(eol_n), 64'(tbl[i].eol_n));
    end

    // Start-up latency from idle
    s_ref = tbl[0].cfg;
    hw_reset();
    chk("ready_idle", 64'(cfg_ready), 64'(1));
    load_cfg(s_ref);
    chk("running_rise", 64'(running), 64'(1));
    first_hs = 0; first_de = 0; n = 0;
    while (first_de == 0 && n < 200) begin
      step(); n++;
      if (first_hs == 0 && !hdmi_hs) first_hs = n;
      if (hdmi_de) begin
        first_de = n;
        chk("first_de_xy_sof", 64'({pix_x, pix_y, sof}), 64'({12'd0, 12'd0, 1'b1}));
      end
    end
    chk("first_hs_latency", 64'(first_hs), 64'(D));
    chk("first_de_latency", 64'(first_de), 64'(D + 23));

    // Mode change mid-frame: waits for the frame boundary
    n = 0;
    while (m_k != 29 && n < 200) begin step(); n++; end
    s_p = s_ref; s_p.ht = 12'd11; s_p.hp = 1'b1;
    load_cfg(s_p);
    chk("ready_drop", 64'(cfg_ready), 64'(0));
    n = 0;
    while (!cfg_ready && n < 300) begin step(); n++; end
    chk("ready_return", 64'(n), 64'(30));
    repeat (D) step();
    hs_n = 0; de_n = 0; ne = 0; e0 = 0; e1 = 0;
    for (int unsigned t = 1; t <= 72; t++) begin
      step();
      hs_n += 32'(hdmi_hs);
      de_n += 32'(hdmi_de);
      if (eol) begin
        if (ne == 0) e0 = t; else if (ne == 1) e1 = t;
        ne++;
      end
    end
    chk("new_hs_active", 64'(hs_n), 64'(12));
    chk("new_de", 64'(de_n), 64'(15));
    chk("new_line_period", 64'(e1 - e0), 64'(12));

    // Offer arriving exactly in the boundary cycle is deferred one frame
    n = 0;
    while (m_k != period(m_cur) - 1 && n < 300) begin step(); n++; end
    s_b = s_ref; s_b.ht = 12'd13;
    cin = s_b; cfg_valid = 1'b1;
    step();
    chk("boundary_pending", 64'(cfg_ready), 64'(0));
    n = 0;
    while (!cfg_ready && n < 300) begin step(); n++; end
    chk("boundary_defer", 64'(n), 64'(72));
    step();
    cfg_valid = 1'b0;
    repeat (D) step();
    ne = 0; e0 = 0; e1 = 0; n = 0;
    while (ne < 2 && n < 300) begin
      step(); n++;
      if (eol) begin
        if (ne == 0) e0 = n; else e1 = n;
        ne++;
      end
    end
    chk("held_line_period", 64'(e1 - e0), 64'(14));

    // Asynchronous reset in the middle of a line
    n = 0;
    while ((m_k % (32'(m_cur.ht) + 1)) != 5 && n < 300) begin step(); n++; end
    #2 reset = 1'b1;
    #1 model_reset();
    check_cycle("async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) step();
    chk("idle_after_reset", 64'(running), 64'(0));

    // Random legal configs offered at random times
    hw_reset();
    repeat (3000) begin
      cfg_valid = ($urandom_range(99, 0) < 4);
      cin = rand_cfg();
      step();
    end
    cfg_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
